// File: rtl/ppc_types.sv
// Shared PowerPC datapath types: condition/exception side-effects and the
// write-back result record buffered in front of each arbiter GPR lane.
package ppc_types;

  localparam int WB_RS_ID_WIDTH = 5;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_WIDTH      = 32;

  // CR0 field (LT/GT/EQ/SO) and XER bits (SO/OV/CA), each with its own update flag.
  typedef struct packed {
    logic [3:0] cr0;
    logic       cr0_valid;
    logic [2:0] xer;
    logic       xer_valid;
  } cond_exception_t;

  typedef struct packed {
    logic [WB_RS_ID_WIDTH-1:0] rs_id;
    logic [GPR_ADDR_WIDTH-1:0] reg_addr;
    logic [GPR_WIDTH-1:0]      result;
    cond_exception_t           cr0_xer;
  } wb_result_t;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order result buffer between one execution unit and one write-back
// arbiter GPR lane; registered-only ready, no fall-through.
module wb_result_fifo
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RS_ID_WIDTH-1:0]       in_rs_id,
  input  logic [4:0]                   in_reg_addr,
  input  logic [31:0]                  in_result,
  input  cond_exception_t              in_cr0_xer,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RS_ID_WIDTH-1:0]       out_rs_id,
  output logic [4:0]                   out_reg_addr,
  output logic [31:0]                  out_result,
  output cond_exception_t              out_cr0_xer,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_result_t       mem [DEPTH];
  wb_result_t       in_entry;
  wb_result_t       head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occ;
  logic             push;
  logic             pop;

  // Explicit compare keeps wrap correct for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (occ != FULL_CNT);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = occ;

  always_comb begin
    in_entry          = '0;
    in_entry.rs_id    = WB_RS_ID_WIDTH'(in_rs_id);
    in_entry.reg_addr = in_reg_addr;
    in_entry.result   = in_result;
    in_entry.cr0_xer  = in_cr0_xer;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the storage array is deliberately not reset,
  // since empty entries are masked by the output mux and never observed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

  // NOTE: every output gets a default first so the mux can never infer a latch.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_rs_id    = RS_ID_WIDTH'(head.rs_id);
  assign out_reg_addr = head.reg_addr;
  assign out_result   = head.result;
  assign out_cr0_xer  = head.cr0_xer;

endmodule
